// File: rtl/dot_product_sequencer_pkg.sv
// Shared geometry defaults and FSM state encoding for the dot-product sequencer.
package dot_product_sequencer_pkg;

    localparam int DEF_N_ELEM  = 8;
    localparam int DEF_ELEM_W  = 4;
    localparam int DEF_RES_W   = 16;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Host write/result bus plus the MAC-facing stream, bundled as one interface.
interface dot_product_sequencer_if
    import dot_product_sequencer_pkg::*;
#(
    parameter int N_ELEM = DEF_N_ELEM,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int RES_W  = DEF_RES_W
) ();
    localparam int IDX_W = $clog2(N_ELEM);

    logic              wr_en;
    logic              wr_sel;
    logic [IDX_W-1:0]  wr_addr;
    logic [ELEM_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic              timeout_err;

    logic              mac_clr;
    logic              mac_en;
    logic [ELEM_W-1:0] mac_a;
    logic [ELEM_W-1:0] mac_b;
    logic              mac_done;
    logic [RES_W-1:0]  mac_result;

    // The master side is the environment: host plus the MAC it talks to.
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, res_ready, mac_done, mac_result,
        input  busy, res_valid, res_data, timeout_err, mac_clr, mac_en, mac_a, mac_b
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, res_ready, mac_done, mac_result,
        output busy, res_valid, res_data, timeout_err, mac_clr, mac_en, mac_a, mac_b
    );

endinterface

// File: rtl/dot_product_sequencer_vec_regfile.sv
// One operand vector: single write port, asynchronous read port, cleared on reset.
module dp_vec_regfile #(
    parameter int N_ELEM = 8,
    parameter int ELEM_W = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      wr_en,
    input  logic [$clog2(N_ELEM)-1:0] wr_addr,
    input  logic [ELEM_W-1:0]         wr_data,
    input  logic [$clog2(N_ELEM)-1:0] rd_addr,
    output logic [ELEM_W-1:0]         rd_data
);

    logic [ELEM_W-1:0] mem [N_ELEM];

    // NOTE: this storage is flops, not a RAM macro, so clearing it on reset is legal and required.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dot_product_sequencer.sv
// Host front end for the 8-element MAC: holds operands, streams pairs, captures the result.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int N_ELEM  = DEF_N_ELEM,
    parameter int ELEM_W  = DEF_ELEM_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                    CLK,
    input logic                    RESET,
    dot_product_sequencer_if.slave bus
);

    localparam int IDX_W  = $clog2(N_ELEM);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [TCNT_W-1:0] tcnt;
    logic [RES_W-1:0]  res_data;
    logic              res_valid;
    logic              timeout_err;
    logic              mac_clr;
    logic              mac_en;
    logic [ELEM_W-1:0] mac_a;
    logic [ELEM_W-1:0] mac_b;

    logic              host_wr;
    logic              wr_a;
    logic              wr_b;
    logic [IDX_W-1:0]  rd_addr;
    logic [ELEM_W-1:0] rd_a;
    logic [ELEM_W-1:0] rd_b;

    assign host_wr = bus.wr_en && (state == S_IDLE);
    assign wr_a    = host_wr && !bus.wr_sel;
    assign wr_b    = host_wr && bus.wr_sel;

    // Read one element ahead so the MAC operands can be registered.
    assign rd_addr = (state == S_STREAM) ? idx + IDX_W'(1) : '0;

    dp_vec_regfile #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) u_vec_a (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (wr_a),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_a)
    );

    dp_vec_regfile #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) u_vec_b (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (wr_b),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_b)
    );

    // NOTE: every state flop uses <= so all updates see the pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            idx         <= '0;
            tcnt        <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            mac_clr     <= 1'b0;
            mac_en      <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
        end else begin
            mac_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mac_clr     <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    idx    <= '0;
                    mac_en <= 1'b1;
                    mac_a  <= rd_a;
                    mac_b  <= rd_b;
                    state  <= S_STREAM;
                end
                S_STREAM: begin
                    if (idx == LAST_IDX) begin
                        mac_en <= 1'b0;
                        mac_a  <= '0;
                        mac_b  <= '0;
                        tcnt   <= '0;
                        state  <= S_WAIT;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        mac_a <= rd_a;
                        mac_b <= rd_b;
                    end
                end
                S_WAIT: begin
                    if (bus.mac_done) begin
                        res_data  <= bus.mac_result;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (tcnt == TCNT_MAX) begin
                        timeout_err <= 1'b1;
                        res_data    <= '0;
                        res_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (res_valid && bus.res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = is_busy(state);
    assign bus.res_valid   = res_valid;
    assign bus.res_data    = res_data;
    assign bus.timeout_err = timeout_err;
    assign bus.mac_clr     = mac_clr;
    assign bus.mac_en      = mac_en;
    assign bus.mac_a       = mac_a;
    assign bus.mac_b       = mac_b;

endmodule
